// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU sequencer slice.
// ALU control codes, LEGv8 opcodes, ALUOp encodings, FSM states.
package alu_seq_pkg;

  localparam logic [3:0] ALUC_AND   = 4'b0000;
  localparam logic [3:0] ALUC_ORR   = 4'b0001;
  localparam logic [3:0] ALUC_ADD   = 4'b0010;
  localparam logic [3:0] ALUC_SUB   = 4'b0110;
  localparam logic [3:0] ALUC_PASSB = 4'b0111;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALUOp + opcode to 4-bit ALU control decode.
// Purely combinational; shared with the single-cycle control path.
module alu_ctrl_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0]  aluop,
  input  logic [10:0] opcode,
  output logic [3:0]  code,
  output logic        illegal
);

  always_comb begin
    code    = ALUC_ADD;
    illegal = 1'b0;
    unique case (aluop)
      ALUOP_MEM: code = ALUC_ADD;
      ALUOP_CBZ: code = ALUC_PASSB;
      ALUOP_RTYPE: begin
        unique case (1'b1)
          (opcode == OPC_ADD): code = ALUC_ADD;
          (opcode == OPC_SUB): code = ALUC_SUB;
          (opcode == OPC_AND): code = ALUC_AND;
          (opcode == OPC_ORR): code = ALUC_ORR;
          default:             illegal = 1'b1;
        endcase
      end
      ALUOP_RSVD: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator for the combinational 64-bit ALU: request in, drive,
// settle, capture R/ZERO, return on a valid/ready response channel.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [10:0]      REQ_OPCODE,
  input  logic [1:0]       REQ_ALUOP,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_C,
  input  logic [WIDTH-1:0] ALU_R,
  input  logic             ALU_ZERO,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_RESULT,
  output logic             RSP_ZERO,
  output logic             RSP_ERR,
  output logic             BUSY
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] dec_code;
  logic       dec_illegal;
  logic       accept;
  logic       capture;

  alu_ctrl_decode u_decode (
    .aluop   (REQ_ALUOP),
    .opcode  (REQ_OPCODE),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  assign accept  = (state == S_IDLE) && REQ_VALID;
  assign capture = (state == S_DRIVE) && (cnt == LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    BUSY      = 1'b1;
    unique case (state)
      S_IDLE: begin
        REQ_READY = 1'b1;
        BUSY      = 1'b0;
        if (accept)
          state_nxt = dec_illegal ? S_RESP : S_DRIVE;
      end
      S_DRIVE: begin
        if (capture) state_nxt = S_RESP;
      end
      S_RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      cnt <= '0;
    else if (state == S_DRIVE)
      cnt <= capture ? 4'd0 : cnt + 4'd1;
  end

  // ALU inputs only move on a legal accept, so the ALU never sees
  // an undecoded control code.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ALU_A      <= '0;
      ALU_B      <= '0;
      ALU_C      <= '0;
      RSP_RESULT <= '0;
      RSP_ZERO   <= 1'b0;
      RSP_ERR    <= 1'b0;
    end else begin
      if (accept && !dec_illegal) begin
        ALU_A <= REQ_A;
        ALU_B <= REQ_B;
        ALU_C <= dec_code;
      end
      if (accept && dec_illegal) begin
        RSP_RESULT <= '0;
        RSP_ZERO   <= 1'b0;
        RSP_ERR    <= 1'b1;
      end
      if (capture) begin
        RSP_RESULT <= ALU_R;
        RSP_ZERO   <= ALU_ZERO;
        RSP_ERR    <= 1'b0;
      end
    end
  end

endmodule
